// File: rtl/rr_select_pkg.sv
// rtl/rr_select_pkg.sv - shared types and constants for the round-robin select arbiter
package rr_select_pkg;

    // Two-state grant FSM: nothing offered, or a grant held until accepted
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rr_state_e;

    // Width of the saturating accepted-grant counter
    localparam int GRANT_CNT_W = 8;
    localparam logic [GRANT_CNT_W-1:0] GRANT_CNT_MAX = {GRANT_CNT_W{1'b1}};

endpackage

// File: rtl/rr_select_arbiter_if.sv
// rtl/rr_select_arbiter_if.sv - request/grant bundle between requesters, arbiter and decoder
interface rr_select_arbiter_if
    import rr_select_pkg::*;
#(
    parameter int m = 3,
    parameter int n = 2 ** m
);
    logic [n-1:0]           req;
    logic                   lock;
    logic                   send_val;
    logic [m-1:0]           send_idx;
    logic                   send_rdy;
    logic [GRANT_CNT_W-1:0] grant_cnt;

    // Arbiter side: consumes requests and the accept, produces the grant
    modport slave (
        input  req,
        input  lock,
        input  send_rdy,
        output send_val,
        output send_idx,
        output grant_cnt
    );

    // Environment side: drives requests and accepts grants
    modport master (
        output req,
        output lock,
        output send_rdy,
        input  send_val,
        input  send_idx,
        input  grant_cnt
    );
endinterface

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin pick: rotate, find-first, unrotate
module rr_priority_pick #(
    parameter int m = 3,
    parameter int n = 2 ** m
) (
    input  logic [n-1:0] req_i,
    input  logic [m-1:0] ptr_i,
    output logic         any_o,
    output logic [m-1:0] winner_o
);
    logic [2*n-1:0] doubled;
    logic [n-1:0]   rotated;
    logic [m-1:0]   offset;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then add ptr back
    always_comb begin
        any_o   = |req_i;
        doubled = {req_i, req_i} >> ptr_i;
        rotated = doubled[n-1:0];
        offset  = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = i[m-1:0];
            end
        end
        // m-bit add wraps modulo n because n == 2**m
        winner_o = ptr_i + offset;
    end
endmodule

// File: rtl/rr_select_arbiter.sv
// rtl/rr_select_arbiter.sv - round-robin arbiter holding a registered grant under val/rdy
module rr_select_arbiter
    import rr_select_pkg::*;
#(
    parameter int m = 3,
    parameter int n = 2 ** m
) (
    input  logic               clk,
    input  logic               reset,
    rr_select_arbiter_if.slave bus
);
    rr_state_e              state_q, state_d;
    logic [m-1:0]           ptr_q, ptr_d;
    logic [m-1:0]           idx_q, idx_d;
    logic [GRANT_CNT_W-1:0] cnt_q, cnt_d;

    logic                   accept;
    logic [m-1:0]           ptr_eff;
    logic                   any;
    logic [m-1:0]           winner;

    // On accept the pointer moves first so the back-to-back pick uses it this cycle
    always_comb begin
        accept  = (state_q == GRANT) && bus.send_rdy;
        ptr_eff = ptr_q;
        if (accept) begin
            ptr_eff = bus.lock ? idx_q : idx_q + 1'b1;
        end
    end

    rr_priority_pick #(
        .m (m),
        .n (n)
    ) u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_eff),
        .any_o    (any),
        .winner_o (winner)
    );

    // Next-state: load a winner from IDLE, hold in GRANT until accepted
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    idx_d   = winner;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (accept) begin
                    ptr_d = ptr_eff;
                    if (cnt_q != GRANT_CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (any) begin
                        idx_d = winner;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any outstanding grant immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.send_val  = (state_q == GRANT);
    assign bus.send_idx  = idx_q;
    assign bus.grant_cnt = cnt_q;
endmodule

// File: tb/tb_rr_select_arbiter.sv
// tb/tb_rr_select_arbiter.sv - self-checking bench for rr_select_arbiter
module tb_rr_select_arbiter;
    localparam int M = 3;
    localparam int N = 8;

    logic clk;
    logic reset;

    rr_select_arbiter_if #(.m(M), .n(N)) bus ();

    rr_select_arbiter #(.m(M), .n(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit busy;
    int mptr;
    int midx;
    int mcnt;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        busy = 0;
        mptr = 0;
        midx = 0;
        mcnt = 0;
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".val"}, int'(bus.send_val), int'(busy));
        check_eq({tag, ".idx"}, int'(bus.send_idx), midx);
        check_eq({tag, ".cnt"}, int'(bus.grant_cnt), mcnt);
    endtask

    // One clock: drive at negedge, advance model, compare just after posedge
    task automatic step(input logic [N-1:0] r, input logic lk, input logic rdy, input string tag);
        @(negedge clk);
        bus.req      = r;
        bus.lock     = lk;
        bus.send_rdy = rdy;
        if (busy && rdy) begin
            if (mcnt < 255) mcnt++;
            mptr = lk ? midx : (midx + 1) % N;
            if (r != 0) midx = pick(r, mptr);
            else busy = 0;
        end else if (!busy && r != 0) begin
            midx = pick(r, mptr);
            busy = 1;
        end
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        logic [N-1:0] r;
        int exp_seq[2];
        exp_seq[0] = 2;
        exp_seq[1] = 7;

        bus.req      = '0;
        bus.lock     = 1'b0;
        bus.send_rdy = 1'b0;
        reset        = 1'b1;
        model_reset();
        #1;
        check_eq("async_reset.val", int'(bus.send_val), 0);
        check_eq("async_reset.idx", int'(bus.send_idx), 0);
        check_eq("async_reset.cnt", int'(bus.grant_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle with no requests
        for (int i = 0; i < 5; i++) step(8'b0000_0000, 1'b0, 1'b1, "idle");

        // Two requesters alternate without lock
        for (int i = 0; i < 5; i++) begin
            step(8'b1000_0100, 1'b0, 1'b1, "alt");
            check_eq("alt.seq", int'(bus.send_idx), exp_seq[i % 2]);
            check_eq("alt.cnt_seq", int'(bus.grant_cnt), i);
        end

        // Held grant survives request changes while not ready
        step(8'b0001_0000, 1'b0, 1'b1, "hold.load");
        check_eq("hold.first", int'(bus.send_idx), 4);
        for (int i = 0; i < 3; i++) begin
            step(8'b0000_0001, 1'b0, 1'b0, "hold");
            check_eq("hold.idx", int'(bus.send_idx), 4);
            check_eq("hold.val", int'(bus.send_val), 1);
        end
        step(8'b0000_0001, 1'b0, 1'b1, "hold.next");
        check_eq("hold.next_idx", int'(bus.send_idx), 0);

        // Lock keeps priority on the current winner, then rotation resumes
        step(8'hFF, 1'b1, 1'b1, "lock");
        check_eq("lock.idx", int'(bus.send_idx), 0);
        for (int i = 1; i <= 3; i++) begin
            step(8'hFF, 1'b0, 1'b1, "unlock");
            check_eq("unlock.idx", int'(bus.send_idx), i);
        end

        // Asynchronous reset in the middle of a grant of index 5
        step(8'b0010_0000, 1'b0, 1'b1, "pre_rst");
        check_eq("pre_rst.idx", int'(bus.send_idx), 5);
        @(negedge clk);
        bus.send_rdy = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("mid_rst.val", int'(bus.send_val), 0);
        check_eq("mid_rst.idx", int'(bus.send_idx), 0);
        @(negedge clk);
        reset = 1'b0;
        step(8'b0010_0000, 1'b0, 1'b0, "post_rst");
        check_eq("post_rst.idx", int'(bus.send_idx), 5);
        check_eq("post_rst.val", int'(bus.send_val), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: r = '0;
                1: r = N'(1) << $urandom_range(0, N - 1);
                default: r = N'($urandom);
            endcase
            step(r, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0), "rand");
        end

        // Counter saturation with a single requester
        for (int i = 0; i < 300; i++) begin
            step(8'b0000_0001, 1'($urandom), 1'b1, "sat");
        end
        check_eq("sat.cnt", int'(bus.grant_cnt), 255);
        check_eq("sat.idx", int'(bus.send_idx), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_select_arbiter.md
# rr_select_arbiter

Round-robin request arbiter that sits directly upstream of the one-hot decoder stage. It watches `n` request lines and picks one fairly. It then presents the winning index (`m` bits) and a valid flag; the downstream decoder uses these as its `x` and `enable` inputs. The grant is held under a val/rdy handshake until the consumer accepts it.

## Interface
- `m`, default 3: index width; must be ≥1.
- `n`, default 2**m: number of request lines; must equal 2**m (no other value supported).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req`  in  n  request vector; bit i high = requester i wants a grant.
- `lock`  in  1  sampled only on an accepted grant; high = keep priority on the current winner.
- `send_val`  out  1  grant valid; drives decoder `enable`.
- `send_idx`  out  m  granted index; drives decoder `x`.
- `send_rdy`  in  1  consumer accepts the grant when `send_val && send_rdy`.
- `grant_cnt`  out  8  count of accepted grants; saturates at 255.

## Operation
- State machine has two states:
  - `IDLE`: `send_val`=0. Moves to `GRANT` when `req != 0`.
  - `GRANT`: `send_val`=1. Leaves only on accept.
- Priority pointer `ptr` (`m` bits) gives the first index searched.
- Pick rule: the winner is the lowest `k` in `0..n-1` such that `req[(ptr+k) mod n]` = 1, and `winner = (ptr+k) mod n`.
- From `IDLE` with `req != 0`:
  - Register the winner into `send_idx`.
  - Go to `GRANT`.
- In `GRANT` without accept:
  - `send_idx` and `send_val` are held stable.
  - This holds even if `req[send_idx]` drops or other bits change; no retraction, no re-arbitration.
- In `GRANT` on accept:
  - If `lock`=1, `ptr` ← `send_idx`. Otherwise `ptr` ← `send_idx`+1; `m`-bit wrap makes n-1 → 0.
  - The next winner is picked the same cycle with the updated `ptr` against the current `req`.
  - If `req != 0`: load the new winner, stay in `GRANT` (back-to-back).
  - Otherwise go to `IDLE`.
- `grant_cnt` increments by 1 on each accept and stops at 255.
- `send_rdy` is ignored while `send_val`=0.
- `send_val` never depends combinationally on `send_rdy`.

## Timing
- Reset values:
  - state=`IDLE`, `send_val`=0, `send_idx`=0, `ptr`=0, `grant_cnt`=0.
  - Outputs take these values asynchronously on reset assertion.
- Reset mid-grant: the grant is dropped, not completed. The first arbitration after release starts from `ptr`=0.
- Latency: `req` first seen high in `IDLE` at edge t gives `send_val`=1 after edge t.
- Throughput:
  - One grant per cycle while `send_rdy`=1 and requests persist.
  - No bubble between back-to-back grants.
  - A one-cycle bubble only after returning to `IDLE`.
- Outputs are registered; `send_idx` is stable for the whole of `send_val`=1 until the accept edge.
- Single requester with `lock`=0: the same index is regranted every cycle, because the pick wraps.

## Structure
- Package `rr_select_pkg`: state enum (`IDLE`, `GRANT`) and the `grant_cnt` width constant (8).
- Sub-module `rr_priority_pick`: combinational (`req`, `ptr`) → (`any`, `winner`), implemented as a rotate / find-first / unrotate. Parameterised by `m`, `n`.
- Top module holds the state register, `ptr`, `send_idx` and the counter.

## Test plan
- Reset, then `req`=8'b0000_0000 for 5 cycles → `send_val`=0, `send_idx`=0, `grant_cnt`=0 throughout.
- `req`=8'b1000_0100, `send_rdy`=1, `lock`=0, held constant → grants 2, 7, 2, 7… on consecutive cycles; `grant_cnt` reaches 4 after 4 accepts.
- `req`=8'b0001_0000, `send_rdy`=0 for 3 cycles while `req` changes to 8'b0000_0001 → `send_idx` stays 4 with `send_val`=1. After `send_rdy`=1, the next grant is 0.
- `req`=8'b1111_1111, `lock`=1 on the accept of index 0 → next grant is 0. Then with `lock`=0 → grants 1, 2, 3.
- Assert `reset` asynchronously mid-cycle during a grant of index 5 → `send_val`=0 and `send_idx`=0 immediately. After release with `req`=8'b0010_0000 → grant 5 one cycle later.
- 300 accepts with `req`=8'b0000_0001 → `grant_cnt` saturates at 255; `send_idx`=0 throughout.
